// File: rtl/irrig_timer_pkg.sv
// Shared types and helpers for the irrigation countdown timer.
// Provides the controller state encoding, the BCD digit type, the digit
// limits used by the borrow chain, and the MM:SS preset validity check.
package irrig_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } irrig_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_UNITS    = 4'd9;
  localparam bcd_digit_t BCD_MAX_SEC_TENS = 4'd5;

  // A preset is usable when every nibble is a decimal digit, the seconds
  // tens digit is at most 5, and the preset is not 00:00.
  function automatic logic bcd_preset_valid(input logic [7:0] mm,
                                            input logic [7:0] ss);
    logic ok;
    ok = (mm[7:4] <= BCD_MAX_UNITS) &&
         (mm[3:0] <= BCD_MAX_UNITS) &&
         (ss[7:4] <= BCD_MAX_SEC_TENS) &&
         (ss[3:0] <= BCD_MAX_UNITS) &&
         ({mm, ss} != 16'h0000);
    return ok;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-count digit with synchronous load.
// Wraps from 0 to MAX on decrement and signals a borrow to the next
// more-significant digit when that wrap happens.
module bcd_down_digit
  import irrig_timer_pkg::*;
#(
  parameter bcd_digit_t MAX = BCD_MAX_UNITS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       dec_en,
  output bcd_digit_t q,
  output logic       borrow_out
);

  bcd_digit_t q_q, q_d;

  // Next digit value: load wins over decrement, otherwise hold.
  always_comb begin
    // NOTE: default assignment first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec_en) begin
      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks so all flops update together.
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q          = q_q;
  assign borrow_out = dec_en & (q_q == 4'd0);

endmodule

// File: rtl/irrigation_timer_ctrl.sv
// Irrigation countdown sequencer: loads a BCD MM:SS preset, counts it down
// once per TICK_DIV clocks, drives the valve while running and handles
// pause / resume / stop and the optional moisture abort.
// Optional feature macro: IRRIG_MOISTURE_ABORT_EN (soil_wet ends a run early).
module irrigation_timer_ctrl
  import irrig_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        soil_wet,
  input  logic [7:0]  preset_min,
  input  logic [7:0]  preset_sec,
  output logic [15:0] digits,
  output logic        valve_on,
  output logic        busy,
  output logic        done,
  output logic        preset_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  irrig_state_t  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          valve_on_q, valve_on_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          preset_err_q, preset_err_d;

  logic          load_en;
  logic          tick_en;
  logic          preset_ok;
  logic          abort_req;

  bcd_digit_t    su_q, st_q, mu_q, mt_q;
  logic          su_borrow, st_borrow, mu_borrow;
  logic          unused_borrow;

`ifdef IRRIG_MOISTURE_ABORT_EN
  assign abort_req = soil_wet;
`else
  logic unused_soil_wet;
  assign abort_req       = 1'b0;
  assign unused_soil_wet = soil_wet;
`endif

  assign digits    = {mt_q, mu_q, st_q, su_q};
  assign preset_ok = bcd_preset_valid(preset_min, preset_sec);

  // Controller next state: stop > abort > pause > start > tick.
  // pause has no meaning in IDLE, so start alone decides there.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    load_en      = 1'b0;
    tick_en      = 1'b0;
    preset_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (preset_ok) begin
            load_en = 1'b1;
            presc_d = '0;
            state_d = ST_RUN;
          end else begin
            preset_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (abort_req) begin
          state_d = ST_DONE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_en = 1'b1;
          // The tick that leaves 00:01 reaches 00:00 and ends the run.
          if (digits == 16'h0001) state_d = ST_DONE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (abort_req) begin
          state_d = ST_DONE;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valve_on_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    // done is reported in the cycle after DONE is reached.
    done_d     = (state_q == ST_DONE);
  end

  // Controller state, prescaler and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      valve_on_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      preset_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      valve_on_q   <= valve_on_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      preset_err_q <= preset_err_d;
    end
  end

  assign valve_on   = valve_on_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign preset_err = preset_err_q;

  bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_sec_units (
    .clock      (clock),
    .reset      (reset),
    .load       (load_en),
    .load_val   (preset_sec[3:0]),
    .dec_en     (tick_en),
    .q          (su_q),
    .borrow_out (su_borrow)
  );

  bcd_down_digit #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (load_en),
    .load_val   (preset_sec[7:4]),
    .dec_en     (su_borrow),
    .q          (st_q),
    .borrow_out (st_borrow)
  );

  bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_min_units (
    .clock      (clock),
    .reset      (reset),
    .load       (load_en),
    .load_val   (preset_min[3:0]),
    .dec_en     (st_borrow),
    .q          (mu_q),
    .borrow_out (mu_borrow)
  );

  // The top digit never borrows in a legal run since 00:00 ends the count.
  bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_min_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (load_en),
    .load_val   (preset_min[7:4]),
    .dec_en     (mu_borrow),
    .q          (mt_q),
    .borrow_out (unused_borrow)
  );

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// Self-checking bench for irrigation_timer_ctrl with TICK_DIV=4.
// The reference model tracks the remaining time as a plain number of
// seconds and a cycle count within the current second.
module tb_irrigation_timer_ctrl;

  localparam int TD = 4;

`ifdef IRRIG_MOISTURE_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        soil_wet = 1'b0;
  logic [7:0]  preset_min = 8'h00;
  logic [7:0]  preset_sec = 8'h00;
  logic [15:0] digits;
  logic        valve_on, busy, done, preset_err;

  int tests = 0;
  int fails = 0;

  int   m_mode;
  int   m_secs;
  int   m_phase;
  logic e_valve, e_busy, e_done, e_err;

  irrigation_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .soil_wet   (soil_wet),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .digits     (digits),
    .valve_on   (valve_on),
    .busy       (busy),
    .done       (done),
    .preset_err (preset_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Preset as total seconds; 0 means the preset is unusable.
  function automatic int preset_secs(input logic [7:0] mm, input logic [7:0] ss);
    int mt, mu, st, su;
    mt = int'(mm[7:4]); mu = int'(mm[3:0]);
    st = int'(ss[7:4]); su = int'(ss[3:0]);
    if (mt > 9 || mu > 9 || st > 5 || su > 9) return 0;
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int s);
    int mins, rem;
    mins = s / 60;
    rem  = s % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(rem / 10), 4'(rem % 10)};
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_secs  = 0;
    m_phase = 0;
    e_valve = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  p;
    logic ab;
    ab     = ABORT_EN && soil_wet;
    e_done = (m_mode == M_DONE);
    e_err  = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (start && !stop) begin
          p = preset_secs(preset_min, preset_sec);
          if (p > 0) begin
            m_secs  = p;
            m_phase = 0;
            m_mode  = M_RUN;
          end else begin
            e_err = 1'b1;
          end
        end
      end
      M_RUN: begin
        if (stop)       m_mode = M_IDLE;
        else if (ab)    m_mode = M_DONE;
        else if (pause) m_mode = M_PAUSE;
        else begin
          m_phase++;
          if (m_phase == TD) begin
            m_phase = 0;
            m_secs--;
            if (m_secs == 0) m_mode = M_DONE;
          end
        end
      end
      M_PAUSE: begin
        if (stop)       m_mode = M_IDLE;
        else if (ab)    m_mode = M_DONE;
        else if (start) m_mode = M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
    e_valve = (m_mode == M_RUN);
    e_busy  = (m_mode == M_RUN) || (m_mode == M_PAUSE);
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".digits"},     digits,             secs_to_bcd(m_secs));
    check({tag, ".valve_on"},   {15'd0, valve_on},  {15'd0, e_valve});
    check({tag, ".busy"},       {15'd0, busy},      {15'd0, e_busy});
    check({tag, ".done"},       {15'd0, done},      {15'd0, e_done});
    check({tag, ".preset_err"}, {15'd0, preset_err}, {15'd0, e_err});
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    int n_done;
    int n_valve;
    logic [7:0] bad_min [3];
    logic [7:0] bad_sec [3];

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all("reset");
    check("reset.digits_zero", digits, 16'h0000);
    reset = 1'b0;
    step("idle");

    // 00:03 countdown
    preset_min = 8'h00; preset_sec = 8'h03; start = 1'b1;
    step("t1.start");
    start = 1'b0;
    check("t1.valve_first", {15'd0, valve_on}, 16'd1);
    check("t1.load", digits, 16'h0003);
    n_done = 0; n_valve = 1;
    for (int i = 0; i < 16; i++) begin
      step("t1.run");
      if (done) n_done++;
      if (valve_on) n_valve++;
    end
    check("t1.done_pulses", 16'(n_done), 16'd1);
    check("t1.valve_cycles", 16'(n_valve), 16'd12);
    check("t1.final", digits, 16'h0000);

    // 01:00 with one tick -> 00:59
    preset_min = 8'h01; preset_sec = 8'h00; start = 1'b1;
    step("t2.start");
    start = 1'b0;
    repeat (4) step("t2.run");
    check("t2.borrow", digits, 16'h0059);
    stop = 1'b1;
    step("t2.stop");
    stop = 1'b0;
    check("t2.stop_busy", {15'd0, busy}, 16'd0);
    check("t2.stop_hold", digits, 16'h0059);
    step("t2.idle");

    // Pause at prescaler 2, hold, resume
    preset_min = 8'h00; preset_sec = 8'h05; start = 1'b1;
    step("t3.start");
    start = 1'b0;
    repeat (2) step("t3.run");
    pause = 1'b1;
    step("t3.pause");
    pause = 1'b0;
    check("t3.pause_valve", {15'd0, valve_on}, 16'd0);
    repeat (10) step("t3.hold");
    check("t3.hold_digits", digits, 16'h0005);
    start = 1'b1;
    step("t3.resume");
    start = 1'b0;
    check("t3.resume_valve", {15'd0, valve_on}, 16'd1);
    step("t3.r1");
    check("t3.r1_digits", digits, 16'h0005);
    step("t3.r2");
    check("t3.r2_digits", digits, 16'h0004);
    stop = 1'b1;
    step("t3.stop");
    stop = 1'b0;

    // Rejected presets
    bad_min[0] = 8'h00; bad_sec[0] = 8'h00;
    bad_min[1] = 8'h00; bad_sec[1] = 8'h60;
    bad_min[2] = 8'h0A; bad_sec[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      preset_min = bad_min[i]; preset_sec = bad_sec[i]; start = 1'b1;
      step("t4.start");
      start = 1'b0;
      check("t4.err", {15'd0, preset_err}, 16'd1);
      check("t4.valve", {15'd0, valve_on}, 16'd0);
      step("t4.after");
      check("t4.err_clear", {15'd0, preset_err}, 16'd0);
    end

    // Moisture during RUN at 00:07
    preset_min = 8'h00; preset_sec = 8'h07; start = 1'b1;
    step("t5.start");
    start = 1'b0;
    step("t5.run");
    soil_wet = 1'b1;
    step("t5.wet");
    soil_wet = 1'b0;
    if (ABORT_EN) begin
      check("t5.abort_valve", {15'd0, valve_on}, 16'd0);
      check("t5.abort_hold", digits, 16'h0007);
      step("t5.done");
      check("t5.abort_done", {15'd0, done}, 16'd1);
    end else begin
      check("t5.ignore_valve", {15'd0, valve_on}, 16'd1);
      repeat (2) step("t5.run2");
      check("t5.ignore_count", digits, 16'h0006);
    end
    stop = 1'b1;
    step("t5.stop");
    stop = 1'b0;

    // Asynchronous reset mid-run at 00:05
    preset_min = 8'h00; preset_sec = 8'h05; start = 1'b1;
    step("t6.start");
    start = 1'b0;
    repeat (3) step("t6.run");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("t6.rst_digits", digits, 16'h0000);
    check("t6.rst_valve", {15'd0, valve_on}, 16'd0);
    check("t6.rst_busy", {15'd0, busy}, 16'd0);
    @(posedge clock);
    #1;
    check_all("t6.rst_hold");
    reset = 1'b0;

    // stop together with start in IDLE
    preset_min = 8'h00; preset_sec = 8'h03; start = 1'b1; stop = 1'b1;
    step("t7.stop_start");
    start = 1'b0; stop = 1'b0;
    check("t7.busy", {15'd0, busy}, 16'd0);
    check("t7.digits", digits, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 99) < 15);
      pause    = ($urandom_range(0, 99) < 8);
      stop     = ($urandom_range(0, 99) < 3);
      soil_wet = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 3) != 0) begin
        preset_min = 8'h00;
        preset_sec = 8'($urandom_range(1, 3));
      end else begin
        preset_min = 8'($urandom_range(0, 255));
        preset_sec = 8'($urandom_range(0, 255));
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
